// File: rtl/mest_pro_run_ctrl.sv
// mest_pro_run_ctrl: sequences a mest_pro core through reset, start and run,
// buffers every reported {carry, zero, result} in a show-ahead FIFO, latches
// the final display value and ends runs that never finish via a watchdog.
module mest_pro_run_ctrl #(
  parameter int RESULT_WIDTH   = 8,
  parameter int DISPLAY_WIDTH  = 16,
  parameter int LOG_DEPTH      = 4,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_run,
  input  logic                      i_clear_mem,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_timeout,
  output logic                      o_overflow,
  output logic                      o_cpu_reset_n,
  output logic                      o_cpu_memory_reset,
  output logic                      o_cpu_start,
  input  logic [RESULT_WIDTH-1:0]   i_cpu_result,
  input  logic                      i_cpu_valid_result,
  input  logic                      i_cpu_carry,
  input  logic                      i_cpu_zero_flag,
  input  logic                      i_cpu_all_done,
  input  logic [DISPLAY_WIDTH-1:0]  i_cpu_display,
  input  logic                      i_rd_en,
  output logic [RESULT_WIDTH+1:0]   o_rd_data,
  output logic                      o_empty,
  output logic [LOG_DEPTH:0]        o_fifo_count,
  output logic [15:0]               o_result_count,
  output logic [DISPLAY_WIDTH-1:0]  o_last_display
);

  localparam int DW    = RESULT_WIDTH + 2;
  localparam int CW    = LOG_DEPTH + 1;
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int HW    = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HOLD_RESET = 3'd1,
    S_START      = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [HW-1:0]             r_hold_cnt;
  logic [19:0]               r_wd_cnt;
  logic                      r_clear_mem;
  logic                      w_clear_mem_nxt;
  logic                      w_start_run;
  logic                      w_timeout_hit;

  logic [DW-1:0]             r_mem [DEPTH];
  logic [LOG_DEPTH-1:0]      r_wr_ptr;
  logic [LOG_DEPTH-1:0]      r_rd_ptr;
  logic [LOG_DEPTH-1:0]      w_rd_ptr_inc;
  logic [CW-1:0]             r_count;
  logic [CW-1:0]             w_count_nxt;
  logic [DW-1:0]             r_rd_data;
  logic [DW-1:0]             w_rd_data_nxt;
  logic [DW-1:0]             w_push_data;
  logic                      w_push_req;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_drop;

  logic                      r_busy;
  logic                      r_done;
  logic                      r_timeout;
  logic                      r_overflow;
  logic                      r_cpu_reset_n;
  logic                      r_cpu_memory_reset;
  logic                      r_cpu_start;
  logic                      r_empty;
  logic [15:0]               r_result_count;
  logic [DISPLAY_WIDTH-1:0]  r_last_display;

  // Next-state logic of the run sequencer; a run request restarts from IDLE or DONE only.
  always_comb begin
    w_state_nxt     = r_state;
    w_start_run     = 1'b0;
    w_clear_mem_nxt = r_clear_mem;
    w_timeout_hit   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_run) begin
          w_state_nxt     = S_HOLD_RESET;
          w_start_run     = 1'b1;
          w_clear_mem_nxt = i_clear_mem;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_HOLD_RESET: begin
        if (r_hold_cnt == HW'(RESET_CYCLES - 1)) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_HOLD_RESET;
        end
      end
      S_START: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_cpu_all_done) begin
          w_state_nxt = S_DONE;
        end else if (r_wd_cnt == 20'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt   = S_DONE;
          w_timeout_hit = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus the latched memory-clear request for this run.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_clear_mem <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clear_mem <= w_clear_mem_nxt;
    end
  end

  // Reset-hold length counter and RUN watchdog; both restart from zero on entry.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_hold_cnt <= '0;
      r_wd_cnt   <= 20'd0;
    end else begin
      r_hold_cnt <= (r_state == S_HOLD_RESET) ? r_hold_cnt + HW'(1) : '0;
      r_wd_cnt   <= (r_state == S_RUN) ? r_wd_cnt + 20'd1 : 20'd0;
    end
  end

  // Core-facing and status outputs, registered from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cpu_reset_n      <= 1'b0;
      r_cpu_memory_reset <= 1'b0;
      r_cpu_start        <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
    end else begin
      r_cpu_reset_n      <= (w_state_nxt != S_HOLD_RESET);
      r_cpu_memory_reset <= (w_state_nxt == S_HOLD_RESET) && w_clear_mem_nxt;
      r_cpu_start        <= (w_state_nxt == S_START);
      r_busy             <= (w_state_nxt == S_HOLD_RESET) || (w_state_nxt == S_START) ||
                            (w_state_nxt == S_RUN);
      r_done             <= (w_state_nxt == S_DONE);
    end
  end

  // FIFO control; a drop only happens when full and nothing is leaving in the same cycle.
  always_comb begin
    w_push_data  = {i_cpu_carry, i_cpu_zero_flag, i_cpu_result};
    w_push_req   = (r_state == S_RUN) && i_cpu_valid_result;
    w_full       = (r_count == CW'(DEPTH));
    w_pop        = i_rd_en && (r_count != '0);
    w_push       = w_push_req && (!w_full || w_pop);
    w_drop       = w_push_req && w_full && !w_pop;
    w_rd_ptr_inc = r_rd_ptr + LOG_DEPTH'(1);
    w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    if (w_count_nxt == '0) begin
      w_rd_data_nxt = '0;
    end else if (w_pop) begin
      w_rd_data_nxt = (r_count == CW'(1)) ? w_push_data : r_mem[w_rd_ptr_inc];
    end else if (r_count == '0) begin
      w_rd_data_nxt = w_push_data;
    end else begin
      w_rd_data_nxt = r_rd_data;
    end
  end

  // FIFO storage; contents need no reset because pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // FIFO pointers, occupancy and show-ahead head register; a run start clears them over any pop.
  always_ff @(posedge clk) begin
    if (i_reset || w_start_run) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_empty   <= 1'b1;
    end else begin
      r_wr_ptr  <= w_push ? r_wr_ptr + LOG_DEPTH'(1) : r_wr_ptr;
      r_rd_ptr  <= w_pop ? w_rd_ptr_inc : r_rd_ptr;
      r_count   <= w_count_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_empty   <= (w_count_nxt == '0);
    end
  end

  // Per-run statistics: saturating result count and sticky timeout/overflow flags.
  always_ff @(posedge clk) begin
    if (i_reset || w_start_run) begin
      r_result_count <= 16'd0;
      r_overflow     <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      if (w_push_req && (r_result_count != 16'hFFFF)) begin
        r_result_count <= r_result_count + 16'd1;
      end else begin
        r_result_count <= r_result_count;
      end
      r_overflow <= r_overflow | w_drop;
      r_timeout  <= r_timeout | w_timeout_hit;
    end
  end

  // Final display value; a timed-out run leaves the previous capture in place.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_last_display <= '0;
    end else if ((r_state == S_RUN) && i_cpu_all_done) begin
      r_last_display <= i_cpu_display;
    end else begin
      r_last_display <= r_last_display;
    end
  end

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_timeout          = r_timeout;
  assign o_overflow         = r_overflow;
  assign o_cpu_reset_n      = r_cpu_reset_n;
  assign o_cpu_memory_reset = r_cpu_memory_reset;
  assign o_cpu_start        = r_cpu_start;
  assign o_rd_data          = r_rd_data;
  assign o_empty            = r_empty;
  assign o_fifo_count       = r_count;
  assign o_result_count     = r_result_count;
  assign o_last_display     = r_last_display;

endmodule

// File: tb/tb_mest_pro_run_ctrl.sv
// Directed testbench for mest_pro_run_ctrl. A second instance with a short
// watchdog covers the timeout behaviour.
module tb_mest_pro_run_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Main instance signals
  logic        i_reset = 1'b1, i_run = 1'b0, i_clear_mem = 1'b0;
  logic [7:0]  i_cpu_result = 8'h00;
  logic        i_cpu_valid_result = 1'b0, i_cpu_carry = 1'b0, i_cpu_zero_flag = 1'b0;
  logic        i_cpu_all_done = 1'b0, i_rd_en = 1'b0;
  logic [15:0] i_cpu_display = 16'h0000;
  logic        o_busy, o_done, o_timeout, o_overflow;
  logic        o_cpu_reset_n, o_cpu_memory_reset, o_cpu_start, o_empty;
  logic [9:0]  o_rd_data;
  logic [4:0]  o_fifo_count;
  logic [15:0] o_result_count, o_last_display;

  // Short-watchdog instance signals
  logic        t_reset = 1'b1, t_run = 1'b0, t_all_done = 1'b0;
  logic [15:0] t_display = 16'h0000;
  logic        t_busy, t_done, t_timeout, t_overflow;
  logic        t_cpu_reset_n, t_cpu_memory_reset, t_cpu_start, t_empty;
  logic [9:0]  t_rd_data;
  logic [4:0]  t_fifo_count;
  logic [15:0] t_result_count, t_last_display;

  mest_pro_run_ctrl #(
    .RESULT_WIDTH(8), .DISPLAY_WIDTH(16), .LOG_DEPTH(4),
    .RESET_CYCLES(4), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_run(i_run), .i_clear_mem(i_clear_mem),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_overflow(o_overflow),
    .o_cpu_reset_n(o_cpu_reset_n), .o_cpu_memory_reset(o_cpu_memory_reset),
    .o_cpu_start(o_cpu_start), .i_cpu_result(i_cpu_result),
    .i_cpu_valid_result(i_cpu_valid_result), .i_cpu_carry(i_cpu_carry),
    .i_cpu_zero_flag(i_cpu_zero_flag), .i_cpu_all_done(i_cpu_all_done),
    .i_cpu_display(i_cpu_display), .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
    .o_empty(o_empty), .o_fifo_count(o_fifo_count),
    .o_result_count(o_result_count), .o_last_display(o_last_display)
  );

  mest_pro_run_ctrl #(
    .RESULT_WIDTH(8), .DISPLAY_WIDTH(16), .LOG_DEPTH(4),
    .RESET_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) dut_t (
    .clk(clk), .i_reset(t_reset), .i_run(t_run), .i_clear_mem(1'b0),
    .o_busy(t_busy), .o_done(t_done), .o_timeout(t_timeout), .o_overflow(t_overflow),
    .o_cpu_reset_n(t_cpu_reset_n), .o_cpu_memory_reset(t_cpu_memory_reset),
    .o_cpu_start(t_cpu_start), .i_cpu_result(8'h00),
    .i_cpu_valid_result(1'b0), .i_cpu_carry(1'b0),
    .i_cpu_zero_flag(1'b0), .i_cpu_all_done(t_all_done),
    .i_cpu_display(t_display), .i_rd_en(1'b0), .o_rd_data(t_rd_data),
    .o_empty(t_empty), .o_fifo_count(t_fifo_count),
    .o_result_count(t_result_count), .o_last_display(t_last_display)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse i_run and advance until the main instance is in RUN (4 hold + 1 start).
  task automatic start_run(input logic clr);
    i_run = 1'b1; i_clear_mem = clr;
    step();
    i_run = 1'b0; i_clear_mem = 1'b0;
    repeat (5) step();
  endtask

  task automatic push(input logic c, input logic z, input logic [7:0] r);
    i_cpu_valid_result = 1'b1; i_cpu_carry = c; i_cpu_zero_flag = z; i_cpu_result = r;
    step();
    i_cpu_valid_result = 1'b0; i_cpu_carry = 1'b0; i_cpu_zero_flag = 1'b0; i_cpu_result = 8'h00;
  endtask

  task automatic finish_run(input logic [15:0] disp);
    i_cpu_all_done = 1'b1; i_cpu_display = disp;
    step();
    i_cpu_all_done = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(); step();
    n_chk++;
    if ({o_busy, o_done, o_timeout, o_overflow, o_cpu_reset_n, o_cpu_memory_reset, o_cpu_start, o_empty} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000001",
               {o_busy, o_done, o_timeout, o_overflow, o_cpu_reset_n, o_cpu_memory_reset, o_cpu_start, o_empty});
    end
    n_chk++;
    if ({o_rd_data, o_fifo_count, o_result_count, o_last_display} !== 47'd0) begin
      n_fail++;
      $display("FAIL reset_data: got rd=%h cnt=%0d res=%0d disp=%h expected all zero",
               o_rd_data, o_fifo_count, o_result_count, o_last_display);
    end
    i_reset = 1'b0;
    step();
    n_chk++;
    if (o_cpu_reset_n !== 1'b1) begin
      n_fail++; $display("FAIL idle_reset_n: got %b expected 1", o_cpu_reset_n);
    end
  endtask

  task automatic test_sequence();
    i_run = 1'b1; i_clear_mem = 1'b1;
    step();
    i_run = 1'b0; i_clear_mem = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({o_cpu_reset_n, o_cpu_memory_reset, o_cpu_start, o_busy} !== 4'b0101) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got rstn/mrst/start/busy=%b expected 0101", k,
                 {o_cpu_reset_n, o_cpu_memory_reset, o_cpu_start, o_busy});
      end
      step();
    end
    n_chk++;
    if ({o_cpu_reset_n, o_cpu_memory_reset, o_cpu_start, o_busy} !== 4'b1011) begin
      n_fail++;
      $display("FAIL start_cycle: got rstn/mrst/start/busy=%b expected 1011",
               {o_cpu_reset_n, o_cpu_memory_reset, o_cpu_start, o_busy});
    end
    step();
    n_chk++;
    if ({o_cpu_start, o_busy, o_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL run_entry: got start/busy/done=%b expected 010", {o_cpu_start, o_busy, o_done});
    end
  endtask

  task automatic test_results();
    push(1'b0, 1'b0, 8'h05);
    n_chk++;
    if (o_rd_data !== 10'h005) begin
      n_fail++; $display("FAIL first_head: got %h expected 005", o_rd_data);
    end
    push(1'b0, 1'b1, 8'h00);
    push(1'b1, 1'b0, 8'hFF);
    finish_run(16'h1234);
    n_chk++;
    if ({o_result_count, o_last_display, o_done, o_busy} !== {16'd3, 16'h1234, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL run_end: got res=%0d disp=%h done=%b busy=%b expected 3 1234 1 0",
               o_result_count, o_last_display, o_done, o_busy);
    end
    // valid_result outside RUN must be ignored
    push(1'b0, 1'b0, 8'h77);
    n_chk++;
    if ({o_fifo_count, o_result_count} !== {5'd3, 16'd3}) begin
      n_fail++;
      $display("FAIL valid_in_done: got cnt=%0d res=%0d expected 3 3", o_fifo_count, o_result_count);
    end
    n_chk++;
    if (o_rd_data !== 10'h005) begin
      n_fail++; $display("FAIL pop0: got %h expected 005", o_rd_data);
    end
    i_rd_en = 1'b1;
    step();
    n_chk++;
    if (o_rd_data !== 10'h100) begin
      n_fail++; $display("FAIL pop1: got %h expected 100", o_rd_data);
    end
    step();
    n_chk++;
    if (o_rd_data !== 10'h2FF) begin
      n_fail++; $display("FAIL pop2: got %h expected 2ff", o_rd_data);
    end
    step();
    n_chk++;
    if ({o_empty, o_fifo_count} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL drained: got empty=%b cnt=%0d expected 1 0", o_empty, o_fifo_count);
    end
    step();   // pop while empty
    i_rd_en = 1'b0;
    n_chk++;
    if ({o_empty, o_fifo_count} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL pop_empty: got empty=%b cnt=%0d expected 1 0", o_empty, o_fifo_count);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] exp [17];
    start_run(1'b0);
    n_chk++;
    if ({o_result_count, o_fifo_count, o_done, o_busy} !== {16'd0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_clear: got res=%0d cnt=%0d done=%b busy=%b expected 0 0 0 1",
               o_result_count, o_fifo_count, o_done, o_busy);
    end
    for (int i = 0; i < 17; i++) begin
      exp[i] = {i[0], i[1], 8'(i * 7 + 3)};
      push(exp[i][9], exp[i][8], exp[i][7:0]);
    end
    n_chk++;
    if ({o_fifo_count, o_overflow, o_result_count} !== {5'd16, 1'b1, 16'd17}) begin
      n_fail++;
      $display("FAIL overflow: got cnt=%0d ovf=%b res=%0d expected 16 1 17",
               o_fifo_count, o_overflow, o_result_count);
    end
    i_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (o_rd_data !== exp[i]) begin
        n_fail++; $display("FAIL ovf_order%0d: got %h expected %h", i, o_rd_data, exp[i]);
      end
      step();
    end
    i_rd_en = 1'b0;
    n_chk++;
    if (o_empty !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drained: got empty=%b expected 1", o_empty);
    end
    finish_run(16'hBEEF);
  endtask

  task automatic test_full_push_pop();
    logic [9:0] exp [16];
    start_run(1'b0);
    for (int i = 0; i < 16; i++) begin
      exp[i] = {1'b0, i[0], 8'(i * 11 + 2)};
      push(exp[i][9], exp[i][8], exp[i][7:0]);
    end
    n_chk++;
    if ({o_fifo_count, o_overflow} !== {5'd16, 1'b0}) begin
      n_fail++; $display("FAIL full: got cnt=%0d ovf=%b expected 16 0", o_fifo_count, o_overflow);
    end
    i_rd_en = 1'b1;
    push(1'b1, 1'b1, 8'hAA);
    n_chk++;
    if ({o_fifo_count, o_overflow, o_rd_data} !== {5'd16, 1'b0, exp[1]}) begin
      n_fail++;
      $display("FAIL full_push_pop: got cnt=%0d ovf=%b head=%h expected 16 0 %h",
               o_fifo_count, o_overflow, o_rd_data, exp[1]);
    end
    for (int i = 1; i < 17; i++) begin
      n_chk++;
      if (o_rd_data !== ((i == 16) ? 10'h3AA : exp[i])) begin
        n_fail++; $display("FAIL fpp_order%0d: got %h expected %h", i, o_rd_data,
                           ((i == 16) ? 10'h3AA : exp[i]));
      end
      step();
    end
    i_rd_en = 1'b0;
    n_chk++;
    if ({o_empty, o_result_count} !== {1'b1, 16'd17}) begin
      n_fail++; $display("FAIL fpp_end: got empty=%b res=%0d expected 1 17", o_empty, o_result_count);
    end
    finish_run(16'hCAFE);
  endtask

  task automatic test_timeout();
    t_reset = 1'b1; step();
    t_reset = 1'b0; step();
    // First run finishes normally and captures 0x5A5A
    t_run = 1'b1; step(); t_run = 1'b0;
    repeat (5) step();
    t_all_done = 1'b1; t_display = 16'h5A5A; step(); t_all_done = 1'b0;
    n_chk++;
    if ({t_done, t_timeout, t_last_display} !== {1'b1, 1'b0, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL t_first_run: got done=%b to=%b disp=%h expected 1 0 5a5a", t_done, t_timeout, t_last_display);
    end
    // Second run never completes
    t_display = 16'h1111;
    t_run = 1'b1; step(); t_run = 1'b0;
    repeat (5) step();
    for (int k = 1; k < 10; k++) begin
      step();
      n_chk++;
      if ({t_busy, t_done, t_timeout} !== 3'b100) begin
        n_fail++;
        $display("FAIL t_run_cycle%0d: got busy/done/to=%b expected 100", k, {t_busy, t_done, t_timeout});
      end
    end
    step();
    n_chk++;
    if ({t_busy, t_done, t_timeout, t_last_display} !== {3'b011, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL t_timeout: got busy/done/to=%b disp=%h expected 011 5a5a",
               {t_busy, t_done, t_timeout}, t_last_display);
    end
    t_run = 1'b1; step(); t_run = 1'b0;
    n_chk++;
    if ({t_timeout, t_busy} !== 2'b01) begin
      n_fail++; $display("FAIL t_rerun_clear: got to/busy=%b expected 01", {t_timeout, t_busy});
    end
  endtask

  task automatic test_reset_midrun();
    i_run = 1'b1; step(); i_run = 1'b0;
    step();
    i_run = 1'b1; step(); i_run = 1'b0;   // pulse during HOLD_RESET
    step();
    n_chk++;
    if ({o_cpu_reset_n, o_cpu_start} !== 2'b00) begin
      n_fail++; $display("FAIL hold_ignore_run: got rstn/start=%b expected 00", {o_cpu_reset_n, o_cpu_start});
    end
    step();
    n_chk++;
    if ({o_cpu_reset_n, o_cpu_start} !== 2'b11) begin
      n_fail++; $display("FAIL hold_len_kept: got rstn/start=%b expected 11", {o_cpu_reset_n, o_cpu_start});
    end
    step();
    push(1'b0, 1'b0, 8'h11);
    push(1'b0, 1'b0, 8'h22);
    push(1'b0, 1'b0, 8'h33);
    i_run = 1'b1; step(); i_run = 1'b0;   // pulse during RUN
    n_chk++;
    if ({o_busy, o_fifo_count, o_result_count} !== {1'b1, 5'd3, 16'd3}) begin
      n_fail++;
      $display("FAIL run_ignore_run: got busy=%b cnt=%0d res=%0d expected 1 3 3",
               o_busy, o_fifo_count, o_result_count);
    end
    i_reset = 1'b1; step();
    n_chk++;
    if ({o_busy, o_done, o_fifo_count, o_empty, o_cpu_reset_n, o_result_count} !==
        {1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b done=%b cnt=%0d empty=%b rstn=%b res=%0d expected 0 0 0 1 0 0",
               o_busy, o_done, o_fifo_count, o_empty, o_cpu_reset_n, o_result_count);
    end
    i_reset = 1'b0; step();
    n_chk++;
    if ({o_cpu_reset_n, o_busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: got rstn/busy=%b expected 10", {o_cpu_reset_n, o_busy});
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_results();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mest_pro_run_ctrl.md
Name: mest_pro_run_ctrl

Overview:
Synthesizable run controller that sits on the control/observation side of the mest_pro core, opposite the core's own ports. It drives the core's reset, memory-reset and start inputs as a sequenced run. It captures every {carry, zero, result} the core reports into a show-ahead result FIFO and latches the final display value on all_done. A timeout watchdog ends runs that never finish. This lets a board-level host or a bench launch and drain a program run without hand-built stimulus.

Parameters:
RESULT_WIDTH, 8, width of core o_result.
DISPLAY_WIDTH, 16, width of core o_display (matches OUTPUT_MEM_WIDTH).
LOG_DEPTH, 4, result FIFO depth = 2**LOG_DEPTH entries.
RESET_CYCLES, 4, cycles core reset is held low per run (>=1).
TIMEOUT_CYCLES, 65535, max RUN-state cycles before timeout (>=1, fits in 20 bits).

Ports:
clk  in  1  single clock, shared with mest_pro.
i_reset  in  1  synchronous active-high reset.
i_run  in  1  run request, sampled only in IDLE or DONE.
i_clear_mem  in  1  sampled with i_run; 1 = assert core memory reset during the reset phase.
o_busy  out  1  high in HOLD_RESET, START and RUN.
o_done  out  1  high in DONE.
o_timeout  out  1  sticky per run; 1 = run ended by watchdog.
o_overflow  out  1  sticky per run; 1 = at least one result was dropped because the FIFO was full.
o_cpu_reset_n  out  1  to core i_reset_n.
o_cpu_memory_reset  out  1  to core i_memory_reset.
o_cpu_start  out  1  to core i_start.
i_cpu_result  in  RESULT_WIDTH  core o_result.
i_cpu_valid_result  in  1  core o_valid_result.
i_cpu_carry  in  1  core o_carry.
i_cpu_zero_flag  in  1  core o_zero_flag.
i_cpu_all_done  in  1  core o_all_done.
i_cpu_display  in  DISPLAY_WIDTH  core o_display.
i_rd_en  in  1  pop FIFO head.
o_rd_data  out  RESULT_WIDTH+2  FIFO head, packed as {carry, zero, result}; show-ahead.
o_empty  out  1  FIFO empty.
o_fifo_count  out  LOG_DEPTH+1  entries held.
o_result_count  out  16  results reported by the core this run, including dropped ones; saturates at 0xFFFF.
o_last_display  out  DISPLAY_WIDTH  i_cpu_display captured on all_done.

Behaviour:
- Reset values (i_reset high at an edge): state IDLE; o_cpu_reset_n=0; o_cpu_memory_reset=0; o_cpu_start=0; o_busy, o_done, o_timeout, o_overflow = 0; FIFO empty (o_fifo_count=0, o_empty=1); o_rd_data=0; o_result_count=0; o_last_display=0.
- Reset mid-run: same values on the next edge. The core is forced into reset through o_cpu_reset_n=0.
- All outputs are registered.
- IDLE: o_cpu_reset_n=1.
  - i_run=1 at an edge -> HOLD_RESET next cycle.
  - Latch i_clear_mem.
  - Clear the FIFO, o_result_count, o_timeout and o_overflow.
- HOLD_RESET: exactly RESET_CYCLES cycles.
  - o_cpu_reset_n=0.
  - o_cpu_memory_reset = latched clear_mem.
  - Then -> START.
- START: 1 cycle; o_cpu_reset_n=1, o_cpu_start=1, memory reset 0; -> RUN.
- RUN: watchdog counts from 0, one count per cycle.
  - i_cpu_all_done=1 -> DONE; capture i_cpu_display into o_last_display.
  - Otherwise, counter reaching TIMEOUT_CYCLES-1 -> DONE with o_timeout=1; o_last_display unchanged.
- DONE: o_done=1; core is left running, not reset.
  - i_run=1 behaves as in IDLE, re-entering HOLD_RESET.
- i_run in HOLD_RESET, START or RUN: ignored.
- Capture: in RUN only, i_cpu_valid_result=1 -> increment o_result_count, push {carry, zero, result}.
  - valid_result and all_done in the same cycle: the result is captured, then DONE.
  - valid_result outside RUN: ignored.
- FIFO, circular pointers wrapping at 2**LOG_DEPTH:
  - Push when full with no pop: data dropped, o_overflow set, count unchanged.
  - Push and pop when full: both happen, count unchanged.
  - Push and pop when empty: push only; the new word appears on o_rd_data next cycle.
  - Pop when empty: ignored.
  - o_rd_data shows the head one cycle after it is written or after the previous pop.
- The FIFO may be drained in any state. The clear on run start wins over a same-cycle pop.

Test Plan:
1. Reset, then i_run=1 with i_clear_mem=1 -> o_cpu_reset_n=0 and o_cpu_memory_reset=1 for 4 cycles. Then o_cpu_start=1 for exactly 1 cycle, then o_busy=1 in RUN.
2. Core model emits results 0x05 (carry=0, zero=0), 0x00 (carry=0, zero=1) and 0xFF (carry=1, zero=0), then all_done with display=0x1234. Required: o_result_count=3, o_last_display=0x1234, o_done=1. Pops return 0x005, 0x100, 0x2FF, then o_empty=1.
3. 17 results with no reads, LOG_DEPTH=4 -> o_fifo_count=16, o_overflow=1, o_result_count=17. The first 16 values are preserved in order.
4. Full FIFO with simultaneous push and pop -> o_fifo_count stays 16 and o_overflow stays 0.
5. TIMEOUT_CYCLES=10 and all_done never asserted -> DONE after 10 RUN cycles, o_timeout=1, o_last_display unchanged. A new i_run clears o_timeout.
6. i_reset during RUN with 3 results buffered -> the next cycle shows IDLE, o_fifo_count=0, o_cpu_reset_n=0; o_cpu_reset_n returns to 1 after reset drops. i_run pulses during HOLD_RESET or RUN are ignored.
